ram_stream_reader: RTL and testbench



---
 rtl/ram_stream_reader_if.sv | 29 ++
 rtl/ram_stream_reader.sv | 172 +++++++++++++++++
 tb/tb_ram_stream_reader.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/ram_stream_reader_if.sv
// ram_stream_reader_if
// Valid/ready output stream of the RAM read controller.
//   out_valid : a word is available on out_data
//   out_ready : consumer accepts the word this cycle
//   out_data  : stream word (MEM_WIDTH bits)
//   out_last  : marks the final word of a job
// Modports: master = stream producer (the reader), slave = consumer.
interface ram_stream_reader_if #(
    parameter int MEM_WIDTH = 64
) ();
    logic                 out_valid;
    logic                 out_ready;
    logic [MEM_WIDTH-1:0] out_data;
    logic                 out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/ram_stream_reader.sv
// ram_stream_reader
// Read-side controller for a simple-dual-port RAM. Issues sequential read
// addresses, tracks the RAM's fixed read latency with a valid pipe, and
// hands the returned words to a valid/ready stream through a small
// credit-protected register FIFO, so no word is lost under backpressure.
// Ports:
//   clk, rst            : clock and synchronous active-high reset
//   start, start_addr,  : job request (sampled only when idle), first
//   num_words             address and word count (0 .. 2^MEM_DEPTH)
//   raddr               : registered read address to the RAM
//   ram_dout            : RAM read data, L = READ_LATENCY+OUTPUT_REG cycles
//                         after raddr
//   strm                : output stream (valid/ready/data/last)
//   busy, done          : busy while not idle; done pulses at job end
module ram_stream_reader #(
    parameter int MEM_WIDTH    = 64,
    parameter int MEM_DEPTH    = 10,
    parameter int READ_LATENCY = 1,
    parameter int OUTPUT_REG   = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [MEM_DEPTH-1:0] start_addr,
    input  logic [MEM_DEPTH:0]   num_words,
    output logic [MEM_DEPTH-1:0] raddr,
    input  logic [MEM_WIDTH-1:0] ram_dout,
    ram_stream_reader_if.master  strm,
    output logic                 busy,
    output logic                 done
);
    localparam int L         = READ_LATENCY + OUTPUT_REG;
    localparam int BUF_DEPTH = L + 2;
    localparam int CNT_W     = $clog2(BUF_DEPTH + 1);
    localparam int PTR_W     = $clog2(BUF_DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]           state_reg, state_next;
    logic [MEM_DEPTH-1:0] raddr_reg;
    logic [MEM_DEPTH:0]   remaining_reg;   // reads still to be issued
    logic [L-1:0]         pipe_valid_reg;
    logic [L-1:0]         pipe_last_reg;
    logic [MEM_WIDTH-1:0] buf_data_reg [BUF_DEPTH];
    logic [BUF_DEPTH-1:0] buf_last_reg;
    logic [PTR_W-1:0]     rd_ptr_reg, wr_ptr_reg;
    logic [CNT_W-1:0]     occ_reg;

    logic [CNT_W-1:0]     inflight;
    logic [CNT_W:0]       credit_used;
    logic                 out_valid_int;
    logic                 issue, last_issue, push, pop, accept;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        inflight = '0;
        for (int i = 0; i < L; i++) begin
            inflight = inflight + CNT_W'(pipe_valid_reg[i]);
        end
    end

    assign out_valid_int = (occ_reg != '0);
    assign pop           = out_valid_int & strm.out_ready;
    assign push          = pipe_valid_reg[L-1];

    // Every word already in flight or buffered owns a buffer slot; a new
    // read is issued only if a slot remains after this cycle's pop.
    assign credit_used = {1'b0, inflight} + {1'b0, occ_reg} - (CNT_W+1)'(pop);
    assign issue       = (state_reg == S_ISSUE) && (credit_used < (CNT_W+1)'(BUF_DEPTH));
    assign last_issue  = issue && (remaining_reg == (MEM_DEPTH+1)'(1));
    assign accept      = (state_reg == S_IDLE) && start && (num_words != '0);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next = (num_words == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (last_issue) begin
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Leave as the final word is handshaken so done lands in
                // the very next cycle.
                if (inflight == '0 &&
                    (occ_reg == '0 || (occ_reg == CNT_W'(1) && pop))) begin
                    state_next = S_DONE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            raddr_reg     <= '0;
            remaining_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                raddr_reg     <= start_addr;
                remaining_reg <= num_words;
            end else if (issue) begin
                raddr_reg     <= raddr_reg + 1'b1;   // wraps modulo depth
                remaining_reg <= remaining_reg - 1'b1;
            end
        end
    end

    // Valid/last pipe aligned with the RAM read latency; only real issues
    // carry a valid bit, so the RAM's every-cycle reads are ignored.
    generate
        for (genvar gi = 0; gi < L; gi++) begin : g_pipe
            always_ff @(posedge clk) begin
                if (rst) begin
                    pipe_valid_reg[gi] <= 1'b0;
                    pipe_last_reg[gi]  <= 1'b0;
                end else begin
                    if (gi == 0) begin
                        pipe_valid_reg[gi] <= issue;
                        pipe_last_reg[gi]  <= last_issue;
                    end else begin
                        pipe_valid_reg[gi] <= pipe_valid_reg[(gi == 0) ? 0 : gi-1];
                        pipe_last_reg[gi]  <= pipe_last_reg[(gi == 0) ? 0 : gi-1];
                    end
                end
            end
        end
    endgenerate

    // Buffer storage needs no reset: the outputs are gated by occupancy.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_data_reg[wr_ptr_reg] <= ram_dout;
            buf_last_reg[wr_ptr_reg] <= pipe_last_reg[L-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            occ_reg    <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (pop) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            occ_reg <= occ_reg + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign raddr          = raddr_reg;
    assign strm.out_valid = out_valid_int;
    assign strm.out_data  = out_valid_int ? buf_data_reg[rd_ptr_reg] : '0;
    assign strm.out_last  = out_valid_int & buf_last_reg[rd_ptr_reg];
    assign busy           = (state_reg != S_IDLE);
    assign done           = (state_reg == S_DONE);
endmodule

// File: tb/tb_ram_stream_reader.sv
// Bench for ram_stream_reader with MEM_DEPTH=4, READ_LATENCY=2,
// OUTPUT_REG=1 (L=3, buffer depth 5) and a RAM model holding mem[i]=100+i.
module tb_ram_stream_reader;
    localparam int MW = 64;
    localparam int MD = 4;
    localparam int LAT = 3;
    localparam int BUFD = LAT + 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [MD-1:0] start_addr;
    logic [MD:0]   num_words;
    logic [MD-1:0] raddr;
    logic [MW-1:0] ram_dout;
    logic          busy, done;

    ram_stream_reader_if #(.MEM_WIDTH(MW)) s_if ();

    ram_stream_reader #(
        .MEM_WIDTH(MW), .MEM_DEPTH(MD), .READ_LATENCY(2), .OUTPUT_REG(1)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
        .num_words(num_words), .raddr(raddr), .ram_dout(ram_dout),
        .strm(s_if.master), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // RAM model: three register stages between raddr and dout.
    logic [MW-1:0] mem [16];
    logic [MW-1:0] ram_d1, ram_d2;
    always @(posedge clk) begin
        ram_d1   <= mem[raddr];
        ram_d2   <= ram_d1;
        ram_dout <= ram_d2;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_raddr"}, 64'(raddr), 0);
        chk({pfx, "_valid"}, 64'(s_if.out_valid), 0);
        chk({pfx, "_data"}, s_if.out_data, 0);
        chk({pfx, "_last"}, 64'(s_if.out_last), 0);
        chk({pfx, "_busy"}, 64'(busy), 0);
        chk({pfx, "_done"}, 64'(done), 0);
    endtask

    function automatic logic ready_for(input int policy, input int k);
        if (policy == 0) return 1'b1;
        if (policy == 1) return (k >= 20 && k < 30) ? 1'b0 : ((k / 3) % 2 == 0);
        return ($urandom % 4) != 0;
    endfunction

    // Runs one job from posedge+1 alignment and checks it against the
    // expected word list 100+((sa+i) mod 16), last on word nw-1.
    task automatic run_job(input int sa, input int nw, input int policy, input int glitch_k);
        int k, pops, issues, last_k, done_k, first_k;
        logic [MD-1:0] prev_raddr;
        logic [MW-1:0] held_d;
        logic held_l;
        bit stalled, fin;
        $display("job: start_addr=%0d num_words=%0d policy=%0d", sa, nw, policy);
        start = 1'b1; start_addr = MD'(sa); num_words = (MD+1)'(nw);
        @(posedge clk); #1;
        start = 1'b0;
        k = 0; pops = 0; issues = 0; last_k = -1; done_k = -1; first_k = -1;
        stalled = 0; fin = 0; prev_raddr = '0; held_d = '0; held_l = 1'b0;
        while (!fin) begin
            s_if.out_ready = ready_for(policy, k);
            if (k == glitch_k) begin
                start = 1'b1; start_addr = 4'd7; num_words = 5'd3;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (k == 0) begin
                if (nw > 0) chk("raddr_first", 64'(raddr), 64'(sa));
                prev_raddr = raddr;
            end else if (raddr !== prev_raddr) begin
                issues++;
                prev_raddr = raddr;
            end
            chk("outstanding_le_buf", 64'((issues - pops) <= BUFD), 1);
            if (stalled) begin
                chk("stall_valid", 64'(s_if.out_valid), 1);
                chk("stall_data", s_if.out_data, held_d);
                chk("stall_last", 64'(s_if.out_last), 64'(held_l));
            end
            chk("done", 64'(done), (nw == 0) ? 64'(k == 0) : 64'(last_k >= 0 && k == last_k + 1));
            if (done_k >= 0) begin
                chk("busy_after_done", 64'(busy), 0);
                chk("valid_after_done", 64'(s_if.out_valid), 0);
                fin = 1;
            end else begin
                chk("busy", 64'(busy), 1);
            end
            if (done && done_k < 0) done_k = k;
            if (s_if.out_valid && first_k < 0) begin
                first_k = k;
                if (nw > 0) chk("first_valid_cycle", 64'(k), 64'(LAT + 1));
            end
            if (s_if.out_valid && s_if.out_ready) begin
                chk("no_extra_word", 64'(pops < nw), 1);
                chk("data", s_if.out_data, 64'(100 + ((sa + pops) % 16)));
                chk("last", 64'(s_if.out_last), 64'(pops == nw - 1));
                if (policy == 0) chk("gapless", 64'(k), 64'(LAT + 1 + pops));
                $display("  word %0d: data=%0d last=%0d cycle=%0d", pops, s_if.out_data, s_if.out_last, k);
                pops++;
                if (pops == nw) last_k = k;
            end
            stalled = s_if.out_valid && !s_if.out_ready;
            held_d  = s_if.out_data;
            held_l  = s_if.out_last;
            if (k > 400) begin
                chk("job_timeout", 1, 0);
                fin = 1;
            end
            @(posedge clk); #1;
            k++;
        end
        start = 1'b0;
        chk("word_count", 64'(pops), 64'(nw));
        chk("issue_count", 64'(issues), 64'(nw));
    endtask

    initial begin
        int pops, cyc;
        for (int i = 0; i < 16; i++) mem[i] = 64'(100 + i);
        rst = 1'b1; start = 1'b0; start_addr = '0; num_words = '0;
        s_if.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_reset_outputs("reset");
        @(posedge clk); #1;

        run_job(2, 5, 0, -1);     // basic
        run_job(14, 4, 0, -1);    // wrap-around
        run_job(3, 16, 1, -1);    // backpressure with long stall
        run_job(9, 0, 0, -1);     // zero length
        run_job(1, 6, 0, 6);      // start pulsed mid-job is ignored

        // Reset in the middle of a 10-word job after 3 words.
        $display("job: start_addr=5 num_words=10 reset after 3 words");
        start = 1'b1; start_addr = 4'd5; num_words = 5'd10;
        @(posedge clk); #1;
        start = 1'b0; s_if.out_ready = 1'b1;
        pops = 0; cyc = 0;
        while (pops < 3 && cyc < 50) begin
            @(negedge clk);
            if (s_if.out_valid && s_if.out_ready) pops++;
            @(posedge clk); #1;
            cyc++;
        end
        chk("words_before_reset", 64'(pops), 3);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk_reset_outputs("midjob_reset");
        @(posedge clk); #1;
        run_job(0, 2, 0, -1);

        for (int j = 0; j < 6; j++) begin
            run_job(int'($urandom_range(0, 15)), int'($urandom_range(0, 16)), 2, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
